fetch_unit: RTL

- Instruction fetch stage that sits directly upstream of the instruction line buffer (ILB).
- Holds the program counter and requests 128-byte instruction lines (32 x 32-bit) from the local store.
- Drives the ILB's inst_number (5-bit slot index) and fetch_reset.
- Advances by one dual-issue pair per cycle, handles stalls and branch redirects, and refills on line crossing.

---
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_unit.sv | 96 +++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch unit and its neighbours (decode, local store, ILB).
// The perf counter signals exist only when FETCH_PERF_EN is defined.
interface fetch_unit_if #(parameter int ADDR_W = 15);
    logic                start;
    logic                stall;
    logic                branch_taken;
    logic [0:ADDR_W-1]   branch_target;
    logic                ls_req;
    logic [0:ADDR_W-8]   ls_line_addr;
    logic                ls_ack;
    logic [0:4]          inst_number;
    logic                fetch_reset;
    logic                fetch_valid;
    logic [0:ADDR_W-1]   pc;
`ifdef FETCH_PERF_EN
    logic [0:31]         perf_refills;
    logic [0:31]         perf_stalls;
`endif

    modport master (
        input  start, stall, branch_taken, branch_target, ls_ack,
        output ls_req, ls_line_addr, inst_number, fetch_reset, fetch_valid, pc
`ifdef FETCH_PERF_EN
        , output perf_refills, perf_stalls
`endif
    );

    modport slave (
        output start, stall, branch_taken, branch_target, ls_ack,
        input  ls_req, ls_line_addr, inst_number, fetch_reset, fetch_valid, pc
`ifdef FETCH_PERF_EN
        , input perf_refills, perf_stalls
`endif
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, refills 128-byte lines from local store, feeds ILB one pair per cycle (FETCH_PERF_EN adds counters).
// Latency: all outputs registered; RUN starts the cycle after ls_ack, same-line branch costs one bubble.
// Backpressure: stall holds pc/slot with fetch_valid high; a line refill waits indefinitely on ls_ack.
module fetch_unit #(
    parameter int ADDR_W   = 15,
    parameter int RESET_PC = 0
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master fif
);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t              state, state_nx;
    logic [0:ADDR_W-1]   pc_q, pc_nx;
    logic [0:ADDR_W-1]   tgt_pc, adv_pc;
    logic [0:4]          slot;
    logic                ls_req_q, fetch_reset_q, fetch_valid_q;
    logic [0:4]          inst_q;
    logic                unused_tgt_bits;

    assign slot   = pc_q[ADDR_W-7:ADDR_W-3];
    assign tgt_pc = {fif.branch_target[0:ADDR_W-3], 2'b00};
    // Odd slot issues slot+NOP, so only one word is consumed.
    assign adv_pc = pc_q + (slot[4] ? ADDR_W'(4) : ADDR_W'(8));
    assign unused_tgt_bits = ^fif.branch_target[ADDR_W-2:ADDR_W-1];

    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        case (state)
            IDLE:  if (fif.start) state_nx = FILL;
            FILL:  if (fif.ls_ack) state_nx = RUN;
            FLUSH: state_nx = RUN;
            RUN: begin
                if (fif.branch_taken) begin
                    pc_nx    = tgt_pc;
                    state_nx = (tgt_pc[0:ADDR_W-8] == pc_q[0:ADDR_W-8]) ? FLUSH : FILL;
                end else if (!fif.stall) begin
                    pc_nx = adv_pc;
                    if (adv_pc[0:ADDR_W-8] != pc_q[0:ADDR_W-8])
                        state_nx = FILL;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pc_q          <= ADDR_W'(RESET_PC);
            ls_req_q      <= 1'b0;
            inst_q        <= 5'd0;
            fetch_reset_q <= 1'b1;
            fetch_valid_q <= 1'b0;
        end else begin
            state         <= state_nx;
            pc_q          <= pc_nx;
            ls_req_q      <= (state_nx == FILL);
            inst_q        <= pc_nx[ADDR_W-7:ADDR_W-3];
            fetch_reset_q <= (state_nx != RUN);
            fetch_valid_q <= (state_nx == RUN);
        end
    end

    assign fif.ls_req       = ls_req_q;
    assign fif.ls_line_addr = pc_q[0:ADDR_W-8];
    assign fif.inst_number  = inst_q;
    assign fif.fetch_reset  = fetch_reset_q;
    assign fif.fetch_valid  = fetch_valid_q;
    assign fif.pc           = pc_q;

`ifdef FETCH_PERF_EN
    logic [0:31] perf_refills_q, perf_stalls_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_refills_q <= 32'd0;
            perf_stalls_q  <= 32'd0;
        end else begin
            if (state_nx == FILL && state != FILL && perf_refills_q != 32'hFFFF_FFFF)
                perf_refills_q <= perf_refills_q + 32'd1;
            if (state == RUN && fif.stall && perf_stalls_q != 32'hFFFF_FFFF)
                perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign fif.perf_refills = perf_refills_q;
    assign fif.perf_stalls  = perf_stalls_q;
`else
    // Counter-free build: interface carries no perf signals.
`endif

endmodule
